msrh_disp_buffer: RTL and testbench

MSRH_DISP_BUFFER -- requirements
Module: msrh_disp_buffer

---
 rtl/msrh_disp_buffer.sv | 133 +++++++++++++
 tb/tb_msrh_disp_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/msrh_disp_buffer.sv
// Dispatch buffer between rename and the schedulers: a circular FIFO of dispatch groups.
// Source-ready bits track physical-register wakeups while a group waits in the buffer.
module msrh_disp_buffer #(
   parameter int DEPTH     = 4,
   parameter int DISP_SIZE = 2,
   parameter int RNID_W    = 7,
   parameter int CMT_W     = 6,
   parameter int PAYLOAD_W = 128,
   parameter int TGT_SIZE  = 3
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_flush,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [CMT_W-1:0]              i_cmt_id,
   input  logic [PAYLOAD_W-1:0]          i_payload,
   input  logic [DISP_SIZE*2*RNID_W-1:0] i_rs_rnid,
   input  logic [DISP_SIZE*2-1:0]        i_rs_ready,
   input  logic [TGT_SIZE-1:0]           i_wr_valid,
   input  logic [TGT_SIZE*RNID_W-1:0]    i_wr_rnid,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [CMT_W-1:0]              o_cmt_id,
   output logic [PAYLOAD_W-1:0]          o_payload,
   output logic [DISP_SIZE*2*RNID_W-1:0] o_rs_rnid,
   output logic [DISP_SIZE*2-1:0]        o_rs_ready,
   output logic [$clog2(DEPTH):0]        o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SRC_N = DISP_SIZE * 2;

   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [CMT_W-1:0]        cmt_id_q  [DEPTH];
   logic [CMT_W-1:0]        cmt_id_d  [DEPTH];
   logic [PAYLOAD_W-1:0]    payload_q [DEPTH];
   logic [PAYLOAD_W-1:0]    payload_d [DEPTH];
   logic [SRC_N*RNID_W-1:0] rnid_q    [DEPTH];
   logic [SRC_N*RNID_W-1:0] rnid_d    [DEPTH];
   logic [SRC_N-1:0]        rdy_q     [DEPTH];
   logic [SRC_N-1:0]        rdy_d     [DEPTH];
   logic                    push, pop;

   function automatic logic wake_hit(input logic [RNID_W-1:0]          rnid,
                                     input logic [TGT_SIZE-1:0]        wv,
                                     input logic [TGT_SIZE*RNID_W-1:0] wr);
      logic hit;
      hit = 1'b0;
      for (int t = 0; t < TGT_SIZE; t++) begin
         if (wv[t] && (wr[t*RNID_W +: RNID_W] == rnid)) hit = 1'b1;
      end
      return hit;
   endfunction

   assign o_ready = (count_q < CNT_W'(DEPTH));
   assign o_valid = (count_q != '0);
   assign o_count = count_q;
   assign push    = i_valid & o_ready & ~i_flush;
   assign pop     = o_valid & i_ready & ~i_flush;

   assign o_cmt_id  = cmt_id_q[rd_ptr_q];
   assign o_payload = payload_q[rd_ptr_q];
   assign o_rs_rnid = rnid_q[rd_ptr_q];

   always_comb begin
      o_rs_ready = '0;
      for (int s = 0; s < SRC_N; s++) begin
         o_rs_ready[s] = rdy_q[rd_ptr_q][s] |
                         wake_hit(rnid_q[rd_ptr_q][s*RNID_W +: RNID_W], i_wr_valid, i_wr_rnid);
      end
   end

   always_comb begin
      cmt_id_d  = cmt_id_q;
      payload_d = payload_q;
      rnid_d    = rnid_q;
      rdy_d     = rdy_q;
      wr_ptr_d  = wr_ptr_q + PTR_W'(push);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

      // Idle slots may also be woken; a later push overwrites them anyway.
      for (int e = 0; e < DEPTH; e++) begin
         for (int s = 0; s < SRC_N; s++) begin
            if (wake_hit(rnid_q[e][s*RNID_W +: RNID_W], i_wr_valid, i_wr_rnid)) rdy_d[e][s] = 1'b1;
         end
      end

      if (push) begin
         cmt_id_d[wr_ptr_q]  = i_cmt_id;
         payload_d[wr_ptr_q] = i_payload;
         rnid_d[wr_ptr_q]    = i_rs_rnid;
         for (int s = 0; s < SRC_N; s++) begin
            rdy_d[wr_ptr_q][s] = i_rs_ready[s] |
                                 (i_rs_rnid[s*RNID_W +: RNID_W] == '0) |
                                 wake_hit(i_rs_rnid[s*RNID_W +: RNID_W], i_wr_valid, i_wr_rnid);
         end
      end

      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         for (int e = 0; e < DEPTH; e++) rdy_d[e] = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            cmt_id_q[e]  <= '0;
            payload_q[e] <= '0;
            rnid_q[e]    <= '0;
            rdy_q[e]     <= '0;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         cmt_id_q  <= cmt_id_d;
         payload_q <= payload_d;
         rnid_q    <= rnid_d;
         rdy_q     <= rdy_d;
      end
   end

endmodule

// File: tb/tb_msrh_disp_buffer.sv
// Directed and random stimulus for msrh_disp_buffer, checked against a queue-based model of the buffer.
module tb_msrh_disp_buffer;

   logic         clk, rst_n, flush, valid, rdy_in;
   logic         o_ready, o_valid;
   logic [5:0]   cmt_id, o_cmt_id;
   logic [127:0] payload, o_payload;
   logic [27:0]  rs_rnid, o_rs_rnid;
   logic [3:0]   rs_ready, o_rs_ready;
   logic [2:0]   wr_valid;
   logic [20:0]  wr_rnid;
   logic [2:0]   o_count;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [5:0]   cmt;
      logic [127:0] pl;
      logic [27:0]  rn;
      logic [3:0]   rdy;
   } ent_t;

   ent_t q[$];

   msrh_disp_buffer dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush),
      .i_valid(valid), .o_ready(o_ready), .i_cmt_id(cmt_id), .i_payload(payload),
      .i_rs_rnid(rs_rnid), .i_rs_ready(rs_ready),
      .i_wr_valid(wr_valid), .i_wr_rnid(wr_rnid),
      .o_valid(o_valid), .i_ready(rdy_in), .o_cmt_id(o_cmt_id), .o_payload(o_payload),
      .o_rs_rnid(o_rs_rnid), .o_rs_ready(o_rs_ready), .o_count(o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit woke(input logic [6:0] r);
      for (int t = 0; t < 3; t++) begin
         if (wr_valid[t] && wr_rnid[t*7 +: 7] == r) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [3:0] rdy_now(input ent_t e);
      logic [3:0] r;
      for (int s = 0; s < 4; s++) r[s] = e.rdy[s] | woke(e.rn[s*7 +: 7]);
      return r;
   endfunction

   // Compare outputs mid-cycle, then advance the model across the next rising edge.
   task automatic cyc(input string tag);
      ent_t e;
      bit   do_push, do_pop;
      #1;
      chk({tag, ".count"}, 128'(o_count), 128'(q.size()));
      chk({tag, ".valid"}, 128'(o_valid), 128'(q.size() != 0));
      chk({tag, ".ready"}, 128'(o_ready), 128'(q.size() < 4));
      if (q.size() != 0) begin
         e = q[0];
         chk({tag, ".cmt"},     128'(o_cmt_id),   128'(e.cmt));
         chk({tag, ".payload"}, o_payload,        e.pl);
         chk({tag, ".rnid"},    128'(o_rs_rnid),  128'(e.rn));
         chk({tag, ".rsrdy"},   128'(o_rs_ready), 128'(rdy_now(e)));
      end
      if (flush) begin
         q.delete();
      end else begin
         do_push = valid && (q.size() < 4);
         do_pop  = rdy_in && (q.size() != 0);
         for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            e.rdy = rdy_now(e);
            q[i] = e;
         end
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.cmt = cmt_id;
            e.pl  = payload;
            e.rn  = rs_rnid;
            for (int s = 0; s < 4; s++)
               e.rdy[s] = rs_ready[s] | (rs_rnid[s*7 +: 7] == 7'd0) | woke(rs_rnid[s*7 +: 7]);
            q.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      valid = 0; rdy_in = 0; flush = 0; wr_valid = '0; wr_rnid = '0;
   endtask

   task automatic grp(input logic [5:0] c, input logic [27:0] rn, input logic [3:0] rr);
      valid = 1; cmt_id = c; rn = rn; rs_rnid = rn; rs_ready = rr;
      payload = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      rst_n = 0; cmt_id = '0; payload = '0; rs_rnid = '0; rs_ready = '0;
      idle();
      #12;
      chk("rst.count", 128'(o_count), 128'd0);
      chk("rst.valid", 128'(o_valid), 128'd0);
      chk("rst.ready", 128'(o_ready), 128'd1);
      @(negedge clk);
      rst_n = 1;

      // Fill with i_ready low, then drain in order.
      for (int k = 1; k <= 4; k++) begin
         grp(6'(k), 28'h1234567 * 28'(k), 4'h0);
         cyc("fill");
      end
      idle();
      cyc("full");
      chk("full.count", 128'(o_count), 128'd4);
      chk("full.ready", 128'(o_ready), 128'd0);
      rdy_in = 1;
      for (int k = 1; k <= 4; k++) begin
         chk("drain.order", 128'(o_cmt_id), 128'(k));
         cyc("drain");
      end
      chk("drain.count", 128'(o_count), 128'd0);

      // Alternating push/pop across the pointer wrap.
      for (int k = 0; k < 10; k++) begin
         idle(); grp(6'(10 + k), 28'($urandom), 4'($urandom));
         cyc("wrap.push");
         idle(); rdy_in = 1;
         chk("wrap.cmt", 128'(o_cmt_id), 128'(10 + k));
         cyc("wrap.pop");
      end

      // Wakeup while buffered.
      idle(); grp(6'd20, {21'h0A0B0C, 7'h25}, 4'h0);
      cyc("bwake.push");
      idle(); wr_valid = 3'b010; wr_rnid[13:7] = 7'h25;
      #1 chk("bwake.pulse", 128'(o_rs_ready[0]), 128'd1);
      cyc("bwake.pulse");
      idle();
      #1 chk("bwake.hold", 128'(o_rs_ready[0]), 128'd1);
      cyc("bwake.hold");
      rdy_in = 1; cyc("bwake.drain");

      // Wakeup in the push cycle.
      idle(); grp(6'd21, {21'h0D0E0F, 7'h31}, 4'h0);
      wr_valid = 3'b001; wr_rnid[6:0] = 7'h31;
      cyc("pwake.push");
      idle();
      #1 chk("pwake.stored", 128'(o_rs_ready[0]), 128'd1);
      cyc("pwake.hold");
      rdy_in = 1; cyc("pwake.drain");

      // Simultaneous push/pop at count 3, then refused push at count 4.
      idle();
      for (int k = 0; k < 3; k++) begin
         grp(6'(30 + k), 28'($urandom), 4'h0);
         cyc("c3.fill");
      end
      grp(6'd33, 28'($urandom), 4'h0); rdy_in = 1;
      cyc("c3.pushpop");
      chk("c3.count", 128'(o_count), 128'd3);
      idle(); grp(6'd34, 28'($urandom), 4'h0);
      cyc("c3.tofull");
      grp(6'd35, 28'($urandom), 4'h0);
      cyc("c4.refused");
      chk("c4.count", 128'(o_count), 128'd4);
      chk("c4.ready", 128'(o_ready), 128'd0);

      // Flush with pending push.
      idle(); rdy_in = 1; cyc("pre.flush");
      chk("pre.flush.count", 128'(o_count), 128'd3);
      grp(6'd36, 28'($urandom), 4'h0); flush = 1;
      cyc("flush");
      idle();
      chk("flush.count", 128'(o_count), 128'd0);
      chk("flush.valid", 128'(o_valid), 128'd0);
      cyc("post.flush");

      // Asynchronous reset mid-operation.
      grp(6'd40, 28'($urandom), 4'h0); cyc("mr.a");
      grp(6'd41, 28'($urandom), 4'h0); cyc("mr.b");
      idle();
      rst_n = 0;
      #1;
      q.delete();
      chk("mr.count", 128'(o_count), 128'd0);
      chk("mr.valid", 128'(o_valid), 128'd0);
      chk("mr.ready", 128'(o_ready), 128'd1);
      @(negedge clk);
      rst_n = 1;
      grp(6'd42, 28'($urandom), 4'h0); cyc("mr.push");
      idle(); cyc("mr.first");

      // Random traffic with small RNID space so wakeups hit often.
      for (int n = 0; n < 400; n++) begin
         valid    = ($urandom_range(0, 3) != 0);
         rdy_in   = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 39) == 0);
         cmt_id   = 6'($urandom);
         payload  = {$urandom, $urandom, $urandom, $urandom};
         for (int s = 0; s < 4; s++) rs_rnid[s*7 +: 7] = 7'($urandom_range(0, 15));
         rs_ready = 4'($urandom);
         wr_valid = 3'($urandom);
         for (int t = 0; t < 3; t++) wr_rnid[t*7 +: 7] = 7'($urandom_range(0, 15));
         cyc("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
